// File: rtl/multi_channel_stream_aligner_pkg.sv
// Shared widths and pixel type for the multi-channel stream aligner.
package multi_channel_stream_aligner_pkg;

    localparam int unsigned DEF_EXP_WIDTH  = 5;
    localparam int unsigned DEF_FRAC_WIDTH = 10;
    localparam int unsigned DEF_FP_WIDTH   = 1 + DEF_EXP_WIDTH + DEF_FRAC_WIDTH;

    typedef logic [DEF_FP_WIDTH-1:0] fp_t;

endpackage

// File: rtl/multi_channel_stream_aligner_fifo.sv
// Per-channel skew FIFO: sync, pointer-plus-wrap-bit full detection, registered flags.
module aligner_channel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    // A pop frees a slot in the same cycle, so a full FIFO may accept a write alongside it.
    assign do_rd     = rd_en_i & ~empty_q;
    assign do_wr     = wr_en_i & (~full_q | do_rd);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

    // Pointer advance and next-cycle flag computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Pointer and flag registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/multi_channel_stream_aligner.sv
// Aligns CHANNELS valid-only pixel streams into lock-stepped beats tagged with col/row.
module multi_channel_stream_aligner
    import multi_channel_stream_aligner_pkg::*;
#(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned EXP_WIDTH    = DEF_EXP_WIDTH,
    parameter int unsigned FRAC_WIDTH   = DEF_FRAC_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned IMAGE_WIDTH  = 400,
    parameter int unsigned IMAGE_HEIGHT = 400
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [CHANNELS*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] data_i,
    input  logic [CHANNELS-1:0]                        valid_i,
    output logic [CHANNELS*(1+EXP_WIDTH+FRAC_WIDTH)-1:0] data_o,
    output logic                                       valid_o,
    output logic [$clog2(IMAGE_WIDTH)-1:0]             col_o,
    output logic [$clog2(IMAGE_HEIGHT)-1:0]            row_o,
    output logic                                       frame_done_o,
    output logic [CHANNELS-1:0]                        overflow_o
);

    localparam int unsigned FP_W = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned DW   = CHANNELS * FP_W;
    localparam int unsigned CW   = $clog2(IMAGE_WIDTH);
    localparam int unsigned RW   = $clog2(IMAGE_HEIGHT);

    logic [CHANNELS-1:0] fifo_full;
    logic [CHANNELS-1:0] fifo_empty;
    logic [DW-1:0]       heads;
    logic                pop_c;

    logic [DW-1:0]       data_q, data_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic                done_q, done_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CW-1:0]       pos_col_q, pos_col_d;
    logic [RW-1:0]       pos_row_q, pos_row_d;

    // One skew FIFO per channel, all popped together.
    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
        aligner_channel_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (FP_W)
        ) u_fifo (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .wr_en_i   (valid_i[c]),
            .wr_data_i (data_i[c*FP_W +: FP_W]),
            .rd_en_i   (pop_c),
            .rd_data_o (heads[c*FP_W +: FP_W]),
            .full_o    (fifo_full[c]),
            .empty_o   (fifo_empty[c])
        );
    end

    assign pop_c = ~|fifo_empty;

    // Beat formation: load heads, tag with the raster position of this beat, advance position.
    always_comb begin
        data_d    = data_q;
        valid_d   = pop_c;
        col_d     = col_q;
        row_d     = row_q;
        done_d    = 1'b0;
        pos_col_d = pos_col_q;
        pos_row_d = pos_row_q;
        ovf_d     = ovf_q | (valid_i & fifo_full & {CHANNELS{~pop_c}});
        if (pop_c) begin
            data_d = heads;
            col_d  = pos_col_q;
            row_d  = pos_row_q;
            done_d = (pos_col_q == CW'(IMAGE_WIDTH - 1)) && (pos_row_q == RW'(IMAGE_HEIGHT - 1));
            if (pos_col_q == CW'(IMAGE_WIDTH - 1)) begin
                pos_col_d = '0;
                pos_row_d = (pos_row_q == RW'(IMAGE_HEIGHT - 1)) ? '0 : pos_row_q + RW'(1);
            end else begin
                pos_col_d = pos_col_q + CW'(1);
            end
        end
    end

    // Output and counter registers; reset flushes everything to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= '0;
            pos_col_q <= '0;
            pos_row_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            col_q     <= col_d;
            row_q     <= row_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            pos_col_q <= pos_col_d;
            pos_row_q <= pos_row_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_done_o = done_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_multi_channel_stream_aligner.sv
// Randomized and directed bench for the stream aligner against a queue-based model.
module tb_multi_channel_stream_aligner;
    import multi_channel_stream_aligner_pkg::*;

    localparam int C     = 3;
    localparam int DEPTH = 8;
    localparam int IW    = 5;
    localparam int IH    = 3;
    localparam int FPW   = int'(DEF_FP_WIDTH);
    localparam int CW    = $clog2(IW);
    localparam int RW    = $clog2(IH);

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [C*FPW-1:0]   data_i = '0;
    logic [C-1:0]       valid_i = '0;
    logic [C*FPW-1:0]   data_o;
    logic               valid_o;
    logic [CW-1:0]      col_o;
    logic [RW-1:0]      row_o;
    logic               frame_done_o;
    logic [C-1:0]       overflow_o;

    multi_channel_stream_aligner #(
        .CHANNELS     (C),
        .EXP_WIDTH    (DEF_EXP_WIDTH),
        .FRAC_WIDTH   (DEF_FRAC_WIDTH),
        .FIFO_DEPTH   (DEPTH),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one queue per channel, beats leave when all queues hold a sample.
    fp_t              mq [C][$];
    logic [C*FPW-1:0] exp_data;
    logic             exp_valid;
    logic             exp_fd;
    logic [CW-1:0]    exp_col;
    logic [RW-1:0]    exp_row;
    logic [C-1:0]     exp_ovf;
    int               mcol, mrow, mbeats;
    int               vectors = 0;
    int               miscompares = 0;
    int               cyc = 0;
    int               dut_beats, dut_frames;

    task automatic model_reset();
        for (int c = 0; c < C; c++) mq[c].delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_fd    = 1'b0;
        exp_col   = '0;
        exp_row   = '0;
        exp_ovf   = '0;
        mcol      = 0;
        mrow      = 0;
        mbeats    = 0;
    endtask

    task automatic model_step(input logic [C-1:0] v, input logic [C*FPW-1:0] d);
        bit pop;
        pop = 1'b1;
        for (int c = 0; c < C; c++) if (mq[c].size() == 0) pop = 1'b0;
        exp_valid = pop;
        exp_fd    = 1'b0;
        if (pop) begin
            for (int c = 0; c < C; c++) exp_data[c*FPW +: FPW] = mq[c].pop_front();
            exp_col = CW'(mcol);
            exp_row = RW'(mrow);
            exp_fd  = (mcol == IW - 1) && (mrow == IH - 1);
            mbeats++;
            mcol++;
            if (mcol == IW) begin
                mcol = 0;
                mrow = (mrow + 1) % IH;
            end
        end
        for (int c = 0; c < C; c++) begin
            if (v[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(d[c*FPW +: FPW]);
                else exp_ovf[c] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic [C-1:0] v, input logic [C*FPW-1:0] d);
        valid_i = v;
        data_i  = d;
        @(posedge clk_i);
        model_step(v, d);
        @(negedge clk_i);
        cyc++;
        dut_beats  += int'(valid_o);
        dut_frames += int'(frame_done_o);
    endtask

    task automatic apply_reset();
        rst_i   = 1'b1;
        valid_i = '0;
        @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        rst_i      = 1'b0;
        dut_beats  = 0;
        dut_frames = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        vectors++;
        if (valid_o !== 1'b0 || data_o !== '0 || col_o !== '0 || row_o !== '0 ||
            frame_done_o !== 1'b0 || overflow_o !== '0) begin
            miscompares++;
            $display("FAIL reset got v=%b d=%h c=%0d r=%0d fd=%b ov=%b, want all zero",
                     valid_o, data_o, col_o, row_o, frame_done_o, overflow_o);
        end
        rst_i      = 1'b0;
        dut_beats  = 0;
        dut_frames = 0;
    endtask

    task automatic test_lockstep();
        logic [C*FPW-1:0] d;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < C; c++) d[c*FPW +: FPW] = FPW'(16'h3C00 + i);
            cycle('1, d);
            vectors++;
            if (valid_o !== exp_valid || data_o !== exp_data || col_o !== exp_col ||
                row_o !== exp_row || frame_done_o !== exp_fd || overflow_o !== exp_ovf) begin
                miscompares++;
                $display("FAIL lockstep cyc=%0d got v=%b d=%h c=%0d r=%0d fd=%b ov=%b want v=%b d=%h c=%0d r=%0d fd=%b ov=%b",
                         cyc, valid_o, data_o, col_o, row_o, frame_done_o, overflow_o,
                         exp_valid, exp_data, exp_col, exp_row, exp_fd, exp_ovf);
            end
        end
        // 40 input cycles, first beat one cycle later -> 39 beats, two 15-beat frames.
        vectors++;
        if (dut_beats !== 39 || dut_frames !== 2) begin
            miscompares++;
            $display("FAIL lockstep_count got beats=%0d frames=%0d want beats=39 frames=2",
                     dut_beats, dut_frames);
        end
    endtask

    task automatic test_skew(input int delay, input logic [C-1:0] want_ovf, input string tag);
        logic [C*FPW-1:0] d;
        logic [C-1:0]     v;
        apply_reset();
        for (int t = 0; t < 20 + delay + 3; t++) begin
            for (int c = 0; c < C; c++) begin
                int k;
                k = (c == 1) ? t - delay : t;
                v[c] = (k >= 0) && (k < 20);
                d[c*FPW +: FPW] = FPW'(c * 4096 + k);
            end
            cycle(v, d);
            vectors++;
            if (valid_o !== exp_valid || data_o !== exp_data || col_o !== exp_col ||
                row_o !== exp_row || frame_done_o !== exp_fd || overflow_o !== exp_ovf) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got v=%b d=%h c=%0d r=%0d fd=%b ov=%b want v=%b d=%h c=%0d r=%0d fd=%b ov=%b",
                         tag, cyc, valid_o, data_o, col_o, row_o, frame_done_o, overflow_o,
                         exp_valid, exp_data, exp_col, exp_row, exp_fd, exp_ovf);
            end
        end
        vectors++;
        if (overflow_o !== want_ovf) begin
            miscompares++;
            $display("FAIL %s_ovf got %b want %b", tag, overflow_o, want_ovf);
        end
    endtask

    task automatic test_overflow();
        // Channel 1 lags by 12 > depth 8: channels 0 and 2 fill and drop.
        test_skew(12, 3'b101, "overflow");
        for (int i = 0; i < 5; i++) begin
            cycle('0, '0);
            vectors++;
            if (overflow_o !== 3'b101) begin
                miscompares++;
                $display("FAIL overflow_sticky cyc=%0d got %b want 101", cyc, overflow_o);
            end
        end
        apply_reset();
        vectors++;
        if (overflow_o !== '0 || valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear got ov=%b v=%b want ov=000 v=0", overflow_o, valid_o);
        end
    endtask

    task automatic test_random();
        logic [C*FPW-1:0] d;
        logic [C-1:0]     v;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < C; c++) begin
                v[c] = ($urandom_range(0, 99) < 75);
                d[c*FPW +: FPW] = FPW'($urandom);
            end
            cycle(v, d);
            vectors++;
            if (valid_o !== exp_valid || data_o !== exp_data || col_o !== exp_col ||
                row_o !== exp_row || frame_done_o !== exp_fd || overflow_o !== exp_ovf) begin
                miscompares++;
                $display("FAIL random cyc=%0d got v=%b d=%h c=%0d r=%0d fd=%b ov=%b want v=%b d=%h c=%0d r=%0d fd=%b ov=%b",
                         cyc, valid_o, data_o, col_o, row_o, frame_done_o, overflow_o,
                         exp_valid, exp_data, exp_col, exp_row, exp_fd, exp_ovf);
            end
        end
        vectors++;
        if (dut_beats !== mbeats) begin
            miscompares++;
            $display("FAIL random_beats got %0d want %0d", dut_beats, mbeats);
        end
    endtask

    task automatic test_midreset();
        logic [C*FPW-1:0] d;
        bit               hit;
        apply_reset();
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            for (int c = 0; c < C; c++) d[c*FPW +: FPW] = FPW'($urandom);
            cycle('1, d);
            hit = exp_valid && (exp_col == CW'(2)) && (exp_row == RW'(1));
        end
        vectors++;
        if (!hit || col_o !== CW'(2) || row_o !== RW'(1)) begin
            miscompares++;
            $display("FAIL midreset_reach got c=%0d r=%0d want c=2 r=1 (reached=%0d)", col_o, row_o, hit);
        end
        // Reset while inputs stay valid: nothing may be captured.
        rst_i = 1'b1;
        @(posedge clk_i);
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || col_o !== '0 || row_o !== '0 || data_o !== '0) begin
            miscompares++;
            $display("FAIL midreset_flush got v=%b c=%0d r=%0d d=%h want zeros", valid_o, col_o, row_o, data_o);
        end
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < C; c++) d[c*FPW +: FPW] = FPW'(c * 256 + i);
            cycle('1, d);
            vectors++;
            if (valid_o !== exp_valid || data_o !== exp_data || col_o !== exp_col ||
                row_o !== exp_row || frame_done_o !== exp_fd || overflow_o !== exp_ovf) begin
                miscompares++;
                $display("FAIL midreset cyc=%0d got v=%b d=%h c=%0d r=%0d fd=%b ov=%b want v=%b d=%h c=%0d r=%0d fd=%b ov=%b",
                         cyc, valid_o, data_o, col_o, row_o, frame_done_o, overflow_o,
                         exp_valid, exp_data, exp_col, exp_row, exp_fd, exp_ovf);
            end
        end
    endtask

    initial begin
        dut_beats  = 0;
        dut_frames = 0;
        model_reset();
        test_reset();
        test_lockstep();
        test_skew(5, 3'b000, "skew");
        test_overflow();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
